// File: rtl/fork_join_scheduler.sv
// Fork/join scheduler: launches up to NUM_JOBS delayed a+b jobs on one start
// pulse, serializes results by slot index and signals join-all/any/none.
module fork_join_scheduler #(
  parameter int NUM_JOBS = 4,
  parameter int DATA_W   = 16,
  parameter int DLY_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  input  logic [$clog2(NUM_JOBS)-1:0] load_idx,
  input  logic [DATA_W-1:0]           load_a,
  input  logic [DATA_W-1:0]           load_b,
  input  logic [DLY_W-1:0]            load_dly,
  input  logic                        start,
  input  logic [1:0]                  mode,
  output logic                        busy,
  output logic                        join_done,
  output logic                        res_valid,
  output logic [$clog2(NUM_JOBS)-1:0] res_idx,
  output logic [DATA_W:0]             res_sum,
  output logic [NUM_JOBS-1:0]         job_active
);
  localparam int IDX_W = $clog2(NUM_JOBS);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {J_ALL, J_ANY, J_NONE} join_t;

  state_t state, state_nx;
  join_t  policy;

  logic [DATA_W-1:0] op_a [NUM_JOBS];
  logic [DATA_W-1:0] op_b [NUM_JOBS];
  logic [DLY_W-1:0]  dly  [NUM_JOBS];
  logic [DLY_W-1:0]  cnt  [NUM_JOBS];

  logic [NUM_JOBS-1:0] enable, active, pending;
  logic [NUM_JOBS-1:0] expire, active_nx, pending_nx, sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic                found, last_res, join_hit, joined, join_e1;
  logic                idle_start, launch;

  assign idle_start = (state == IDLE) && start;
  assign launch     = idle_start && (enable != '0);
  assign busy       = (state == RUN);
  assign job_active = active;

  always_comb begin
    expire  = '0;
    sel_oh  = '0;
    sel_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_JOBS; i++) begin
      if (active[i] && cnt[i] == '0) expire[i] = 1'b1;
    end
    // lowest pending index wins; the rest wait for later cycles
    for (int unsigned i = 0; i < NUM_JOBS; i++) begin
      if (pending[i] && !found) begin
        found     = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_oh[i] = 1'b1;
      end
    end
    active_nx  = active & ~expire;
    pending_nx = (pending & ~sel_oh) | expire;
    last_res   = (state == RUN) && found && (active_nx == '0) && (pending_nx == '0);
    case (policy)
      J_ANY:   join_hit = found && !joined;
      J_NONE:  join_hit = 1'b0;
      default: join_hit = last_res;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = RUN;
      RUN:     if (last_res) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // operand storage carries no reset; contents only matter once enabled
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && !start && load_valid && int'(load_idx) < NUM_JOBS) begin
      op_a[load_idx] <= load_a;
      op_b[load_idx] <= load_b;
      dly[load_idx]  <= load_dly;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= '0;
      active    <= '0;
      pending   <= '0;
      join_done <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_sum   <= '0;
      joined    <= 1'b0;
      join_e1   <= 1'b0;
      policy    <= J_ALL;
      for (int unsigned i = 0; i < NUM_JOBS; i++) cnt[i] <= '0;
    end else begin
      res_valid <= found;
      join_done <= join_e1 | join_hit;
      join_e1   <= 1'b0;
      if (found) begin
        res_idx <= sel_idx;
        res_sum <= {1'b0, op_a[sel_idx]} + {1'b0, op_b[sel_idx]};
      end
      if (state == IDLE) begin
        if (idle_start) begin
          join_e1 <= (enable == '0) || (mode == 2'd2);
          joined  <= 1'b0;
          case (mode)
            2'd1:    policy <= J_ANY;
            2'd2:    policy <= J_NONE;
            default: policy <= J_ALL;
          endcase
          if (launch) begin
            active <= enable;
            for (int unsigned i = 0; i < NUM_JOBS; i++) cnt[i] <= dly[i];
          end
        end else if (load_valid && int'(load_idx) < NUM_JOBS) begin
          enable[load_idx] <= 1'b1;
        end
      end else begin
        active  <= active_nx;
        pending <= pending_nx;
        enable  <= enable & ~sel_oh;
        joined  <= joined | join_hit;
        for (int unsigned i = 0; i < NUM_JOBS; i++) begin
          if (active[i] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end
endmodule
